gpu_frame_sequencer: RTL

GPU_FRAME_SEQUENCER -- requirements
Module: gpu_frame_sequencer

---
 rtl/gpu_frame_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gpu_frame_sequencer.sv
// rtl/gpu_frame_sequencer.sv - vertex upload, render arm/start and framebuffer swap sequencer
module gpu_frame_sequencer #(
   parameter int M              = 11,
   parameter int N              = 7,
   parameter int DEPTH          = 16384,
   parameter int SETTLE_CYCLES  = 1600,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      up_valid,
   output logic                      up_ready,
   input  logic [M+N-1:0]            up_data,
   input  logic                      up_last,
   input  logic                      frame_req,
   input  logic                      auto_mode,
   output logic [$clog2(DEPTH)-1:0]  mem_wr_addr,
   output logic [M+N-1:0]            mem_wr_data,
   output logic                      mem_wr_en,
   output logic [31:0]               vertex_count,
   output logic                      gpu_start,
   input  logic                      gpu_frame_end,
   output logic                      fb_sel,
   output logic                      frame_done,
   output logic                      busy,
   output logic                      err_overflow,
   output logic                      err_timeout
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ARM    = 3'd2,
      S_RENDER = 3'd3,
      S_SWAP   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] settle_cnt;
   logic [31:0] tmo_cnt;
   logic        pending;

   logic        accept;
   logic        settle_done;
   logic        tmo_hit;
   logic        start_fire;
   logic        skip_settle;

   assign accept      = up_valid & up_ready;
   assign settle_done = (settle_cnt == 32'(SETTLE_CYCLES));
   assign tmo_hit     = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign start_fire  = (state == S_ARM) && settle_done && pending;
   // ARM entered on a request (not at the end of an upload) starts without settling
   assign skip_settle = (state == S_SWAP) || ((state == S_IDLE) && !accept);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = up_last ? S_ARM : S_LOAD;
            end else if (pending && (vertex_count != 32'd0)) begin
               state_nxt = S_ARM;
            end
         end
         S_LOAD: begin
            if (accept && up_last) begin
               state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            if (start_fire) begin
               state_nxt = S_RENDER;
            end
         end
         S_RENDER: begin
            if (gpu_frame_end) begin
               state_nxt = S_SWAP;
            end else if (tmo_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_SWAP: begin
            state_nxt = (auto_mode || pending) ? S_ARM : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      up_ready  = reset && ((state == S_IDLE) || (state == S_LOAD));
      busy      = (state != S_IDLE);
      gpu_start = start_fire;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_wr_en    <= 1'b0;
         mem_wr_addr  <= '0;
         mem_wr_data  <= '0;
         vertex_count <= 32'd0;
         err_overflow <= 1'b0;
      end else begin
         mem_wr_en <= 1'b0;
         if (accept) begin
            if (state == S_IDLE) begin
               mem_wr_en    <= 1'b1;
               mem_wr_addr  <= '0;
               mem_wr_data  <= up_data;
               vertex_count <= 32'd1;
            end else if (vertex_count < 32'(DEPTH)) begin
               mem_wr_en    <= 1'b1;
               mem_wr_addr  <= vertex_count[AW-1:0];
               mem_wr_data  <= up_data;
               vertex_count <= vertex_count + 32'd1;
            end else begin
               err_overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         settle_cnt  <= 32'd0;
         tmo_cnt     <= 32'd0;
         pending     <= 1'b0;
         fb_sel      <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if ((state_nxt == S_ARM) && (state != S_ARM)) begin
            settle_cnt <= skip_settle ? 32'(SETTLE_CYCLES) : 32'd0;
         end else if ((state == S_ARM) && !settle_done) begin
            settle_cnt <= settle_cnt + 32'd1;
         end

         tmo_cnt <= (state == S_RENDER) ? tmo_cnt + 32'd1 : 32'd0;

         if ((state == S_RENDER) && !gpu_frame_end && tmo_hit) begin
            err_timeout <= 1'b1;
         end

         // auto mode behaves as a request re-issued at every swap
         if (frame_req || ((state == S_SWAP) && auto_mode)) begin
            pending <= 1'b1;
         end else if (start_fire) begin
            pending <= 1'b0;
         end else if ((state == S_IDLE) && !accept && (vertex_count == 32'd0)) begin
            pending <= 1'b0;
         end

         if (state == S_SWAP) begin
            fb_sel <= ~fb_sel;
         end
         frame_done <= (state == S_SWAP);
      end
   end

endmodule
